// File: rtl/posit_decode.sv
// posit_decode: two-stage pipelined posit unpacker.
//
// Stage 1 captures the sign, the zero/NaR flags and the two's-complement magnitude. Stage 2
// decodes the regime run, exponent and fraction of that magnitude into registered outputs.
//
// Ports:
//   clk_i, rst_ni      clock (rising edge), asynchronous active-low reset
//   flush_i            synchronous clear of both pipeline stages
//   valid_i / ready_o  input handshake, posit_i is the packed posit
//   valid_o / ready_i  output handshake
//   sign_o             posit sign bit
//   is_zero_o          input was zero
//   is_nar_o           input was NaR
//   scale_o            signed scale k*2^ES + e
//   frac_o             fraction bits after the hidden 1, MSB-aligned, zero-padded
module posit_decode #(
  parameter int unsigned N  = 32,
  parameter int unsigned ES = 2,
  parameter int unsigned SW = $clog2(N) + ES + 2,
  parameter int unsigned FW = N - ES - 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [N-1:0]  posit_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          sign_o,
  output logic          is_zero_o,
  output logic          is_nar_o,
  output logic [SW-1:0] scale_o,
  output logic [FW-1:0] frac_o
);

  localparam int unsigned BW = N - 1;            // magnitude bits below the sign position
  localparam int unsigned MW = $clog2(N) + 1;    // holds a run length plus one

  // Handshake
  logic s1_valid_q, s2_valid_q;
  logic s1_advance, accept;

  assign s1_advance = !s2_valid_q || ready_i;
  assign ready_o    = !s1_valid_q || s1_advance;
  assign accept     = valid_i && ready_o;

  // Stage 1
  logic          s1_sign_q, s1_zero_q, s1_nar_q;
  logic [BW-1:0] s1_body_q;
  logic [N-1:0]  mag_w;

  assign mag_w = posit_i[N-1] ? (~posit_i + 1'b1) : posit_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_nar_q   <= 1'b0;
      s1_body_q  <= '0;
    end else if (flush_i) begin
      s1_valid_q <= 1'b0;
    end else if (ready_o) begin
      s1_valid_q <= valid_i;
      if (accept) begin
        s1_sign_q <= posit_i[N-1];
        s1_zero_q <= (posit_i == '0);
        // Negating a negative posit leaves the top bit set only for NaR.
        s1_nar_q  <= mag_w[N-1];
        s1_body_q <= mag_w[BW-1:0];
      end
    end
  end

  // Stage 2 combinational decode
  logic          r0_w;
  logic [MW-1:0] m_w, sh_w;
  logic [SW-1:0] mx_w, k_w, e_w, scale_w;
  logic [BW-1:0] rem_w;
  logic [FW-1:0] frac_w;

  always_comb begin
    logic run;
    r0_w = s1_body_q[BW-1];
    m_w  = '0;
    run  = 1'b1;
    for (int i = int'(BW) - 1; i >= 0; i--) begin
      if (run) begin
        if (s1_body_q[i] == r0_w) m_w = m_w + 1'b1;
        else                      run = 1'b0;
      end
    end
  end

  // Shifting out the run and its terminator leaves exponent then fraction at the top;
  // a run that fills the word shifts everything out, so missing bits read as zero.
  assign sh_w    = m_w + 1'b1;
  assign rem_w   = s1_body_q << sh_w;
  assign mx_w    = {{(SW - MW){1'b0}}, m_w};
  assign k_w     = r0_w ? (mx_w - 1'b1) : (-mx_w);
  assign e_w     = SW'(rem_w >> (BW - ES));
  assign scale_w = (k_w << ES) + e_w;
  assign frac_w  = FW'(rem_w >> (BW - ES - FW));

  // Stage 2 registers
  logic          sign_q, zero_q, nar_q;
  logic [SW-1:0] scale_q;
  logic [FW-1:0] frac_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_q <= 1'b0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      nar_q      <= 1'b0;
      scale_q    <= '0;
      frac_q     <= '0;
    end else if (flush_i) begin
      s2_valid_q <= 1'b0;
    end else if (s1_advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sign_q  <= s1_sign_q;
        zero_q  <= s1_zero_q;
        nar_q   <= s1_nar_q;
        scale_q <= (s1_zero_q || s1_nar_q) ? '0 : scale_w;
        frac_q  <= (s1_zero_q || s1_nar_q) ? '0 : frac_w;
      end
    end
  end

  assign valid_o   = s2_valid_q;
  assign sign_o    = sign_q;
  assign is_zero_o = zero_q;
  assign is_nar_o  = nar_q;
  assign scale_o   = scale_q;
  assign frac_o    = frac_q;

endmodule

// File: tb/tb_posit_decode.sv
// tb_posit_decode: self-checking bench for posit_decode (N=32, ES=2).
// A bit-walking reference decoder fills a scoreboard queue on every accepted input; a negedge
// monitor compares every valid output against the queue head and checks ready_o against the
// queue occupancy. Directed cases check fixed constants and latency.
module tb_posit_decode;

  localparam int unsigned N  = 32;
  localparam int unsigned ES = 2;
  localparam int unsigned SW = $clog2(N) + ES + 2;
  localparam int unsigned FW = N - ES - 3;

  logic          clk, rst_ni, flush_i, valid_i, ready_o, valid_o, ready_i;
  logic [N-1:0]  posit_i;
  logic          sign_o, is_zero_o, is_nar_o;
  logic [SW-1:0] scale_o;
  logic [FW-1:0] frac_o;

  posit_decode #(.N(N), .ES(ES), .SW(SW), .FW(FW)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .flush_i  (flush_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .posit_i  (posit_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .sign_o   (sign_o),
    .is_zero_o(is_zero_o),
    .is_nar_o (is_nar_o),
    .scale_o  (scale_o),
    .frac_o   (frac_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic sign;
    logic zero;
    logic nar;
    int   scale;
    int   frac;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_h;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int bit_at(input logic [30:0] b, input int pos);
    return (pos >= 0) ? int'(b[pos]) : 0;
  endfunction

  // Reference: walk the magnitude bits MSB-first as the posit format describes.
  function automatic exp_t ref_decode(input logic [31:0] p);
    exp_t        r;
    logic [31:0] mag;
    logic [30:0] body;
    int          pos, m, k, e, f, r0;
    r.sign  = p[31];
    r.zero  = (p == 32'h0);
    r.nar   = (p == 32'h8000_0000);
    r.scale = 0;
    r.frac  = 0;
    if (r.zero || r.nar) return r;
    mag  = p[31] ? (32'd0 - p) : p;
    body = mag[30:0];
    pos  = 30;
    r0   = bit_at(body, 30);
    m    = 0;
    while (pos >= 0 && bit_at(body, pos) == r0) begin
      m++;
      pos--;
    end
    k = (r0 == 1) ? m - 1 : -m;
    pos--;  // terminator (or nothing left)
    e = 0;
    repeat (ES) begin
      e = e * 2 + bit_at(body, pos);
      pos--;
    end
    f = 0;
    repeat (FW) begin
      f = f * 2 + bit_at(body, pos);
      pos--;
    end
    r.scale = k * (1 << ES) + e;
    r.frac  = f;
    return r;
  endfunction

  // Scoreboard monitor; queue size equals the number of posits held in the pipeline.
  always @(negedge clk) begin
    if (!rst_ni) begin
      exp_q.delete();
    end else begin
      check_eq("ready_o_occupancy", ready_o, (exp_q.size() < 2) || ready_i);
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_valid_o", valid_o, 0);
        end else begin
          mon_h = exp_q[0];
          check_eq("sb_sign", sign_o, mon_h.sign);
          check_eq("sb_zero", is_zero_o, mon_h.zero);
          check_eq("sb_nar", is_nar_o, mon_h.nar);
          check_eq("sb_scale", int'($signed(scale_o)), mon_h.scale);
          check_eq("sb_frac", frac_o, mon_h.frac);
          if (ready_i) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (flush_i) exp_q.delete();
      else if (valid_i && ready_o) exp_q.push_back(ref_decode(posit_i));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    check_eq({tag, "_valid_o"}, valid_o, 0);
    check_eq({tag, "_ready_o"}, ready_o, 1);
    check_eq({tag, "_sign_o"}, sign_o, 0);
    check_eq({tag, "_is_zero_o"}, is_zero_o, 0);
    check_eq({tag, "_is_nar_o"}, is_nar_o, 0);
    check_eq({tag, "_scale_o"}, scale_o, 0);
    check_eq({tag, "_frac_o"}, frac_o, 0);
  endtask

  // Call at posedge+1 with an empty pipeline and ready_i=1. The result is visible after the
  // second rising edge, counting the accepting edge as the first.
  task automatic send_directed(input string tag, input logic [31:0] p, input logic es,
                               input logic ez, input logic en, input int escale,
                               input int efrac);
    valid_i = 1'b1;
    posit_i = p;
    #1;
    check_eq({tag, "_ready_o"}, ready_o, 1);
    tick();
    valid_i = 1'b0;
    check_eq({tag, "_valid_o_early"}, valid_o, 0);
    tick();
    check_eq({tag, "_valid_o"}, valid_o, 1);
    check_eq({tag, "_sign_o"}, sign_o, es);
    check_eq({tag, "_is_zero_o"}, is_zero_o, ez);
    check_eq({tag, "_is_nar_o"}, is_nar_o, en);
    check_eq({tag, "_scale_o"}, int'($signed(scale_o)), escale);
    check_eq({tag, "_frac_o"}, frac_o, efrac);
  endtask

  logic [31:0] vec [8];
  logic [31:0] specials [6] = '{32'h0, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                                32'h8000_0001};

  initial begin
    int  sent, out0;
    logic acc;
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    posit_i = '0;
    #2;
    chk_reset("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_ni = 1'b1;
    tick();

    // Directed decodes
    send_directed("p40", 32'h4000_0000, 0, 0, 0, 0, 0);
    send_directed("p48", 32'h4800_0000, 0, 0, 0, 1, 0);
    send_directed("p44", 32'h4400_0000, 0, 0, 0, 0, 27'h400_0000);
    send_directed("pC0", 32'hC000_0000, 1, 0, 0, 0, 0);
    send_directed("maxpos", 32'h7FFF_FFFF, 0, 0, 0, 120, 0);
    send_directed("minpos", 32'h0000_0001, 0, 0, 0, -120, 0);
    send_directed("zero", 32'h0000_0000, 0, 1, 0, 0, 0);
    send_directed("nar", 32'h8000_0000, 1, 0, 1, 0, 0);
    tick();

    // Streaming with backpressure in cycles 3..6
    foreach (vec[i]) vec[i] = $urandom;
    sent = 0;
    out0 = n_out;
    for (int c = 0; c < 40 && !(sent == 8 && exp_q.size() == 0); c++) begin
      ready_i = !(c >= 3 && c <= 6);
      valid_i = (sent < 8);
      posit_i = vec[sent % 8];
      #1;
      if (c == 4) begin
        check_eq("bp_ready_o_low", ready_o, 0);
        check_eq("bp_valid_o_held", valid_o, 1);
      end
      acc = valid_i && ready_o;
      tick();
      if (acc) sent++;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    check_eq("bp_sent", sent, 8);
    check_eq("bp_outputs", n_out - out0, 8);
    check_eq("bp_drained", exp_q.size(), 0);
    tick();

    // Flush with two posits held and a third offered
    ready_i = 1'b0;
    valid_i = 1'b1;
    posit_i = 32'h5000_0000;
    tick();
    posit_i = 32'h3000_0000;
    tick();
    check_eq("fl_valid_before", valid_o, 1);
    flush_i = 1'b1;
    posit_i = 32'h6000_0000;
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    check_eq("fl_valid_after", valid_o, 0);
    check_eq("fl_ready_after", ready_o, 1);
    ready_i = 1'b1;
    repeat (3) begin
      tick();
      check_eq("fl_stays_empty", valid_o, 0);
    end
    send_directed("post_flush", 32'h4800_0000, 0, 0, 0, 1, 0);
    tick();

    // Asynchronous reset mid-stream
    valid_i = 1'b1;
    posit_i = 32'hC000_0000;
    tick();
    posit_i = 32'hB000_0000;
    tick();
    check_eq("rs_sign_before", sign_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk_reset("mid_reset");
    valid_i = 1'b0;
    @(negedge clk);
    #2 rst_ni = 1'b1;
    tick();
    chk_reset("post_release");
    send_directed("post_reset", 32'h4400_0000, 0, 0, 0, 0, 27'h400_0000);
    tick();

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) posit_i = specials[$urandom_range(0, 5)];
      else                           posit_i = $urandom;
      tick();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (6) tick();
    check_eq("rand_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
